// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional feature macro used by this slice: IFETCH_MISALIGN_TRAP_EN.
package ifetch_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam int unsigned PC_STEP = 4;

    // One buffered fetch result: the PC and the word the ROM returned for it.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    // Force a byte address onto a word boundary.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_if.sv
// Bus bundle between the fetch unit and its environment (ROM, redirect
// source, decode). IFETCH_MISALIGN_TRAP_EN adds the misalignment fault pair.
//
// Decode handshake: a transfer happens on a rising clock edge where
// out_valid and out_ready are both high. out_valid never depends on
// out_ready, and out_pc/out_instr stay stable while out_valid is high and
// out_ready is low. A redirect flushes the buffer regardless of the handshake.
interface ifetch_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
);
    logic [XLEN-1:0]          rom_addr;
    logic [XLEN-1:0]          rom_q;
    logic                     redirect_valid;
    logic [XLEN-1:0]          redirect_pc;
    logic                     out_valid;
    logic                     out_ready;
    logic [XLEN-1:0]          out_instr;
    logic [XLEN-1:0]          out_pc;
    // Number of buffered entries, exposed for observation.
    logic [$clog2(DEPTH):0]   dbg_count;
`ifdef IFETCH_MISALIGN_TRAP_EN
    logic                     misalign_fault;
    logic [XLEN-1:0]          misalign_pc;

    modport master (
        output rom_addr, input rom_q,
        input redirect_valid, input redirect_pc,
        output out_valid, input out_ready, output out_instr, output out_pc,
        output dbg_count, output misalign_fault, output misalign_pc
    );
    modport slave (
        input rom_addr, output rom_q,
        output redirect_valid, output redirect_pc,
        input out_valid, output out_ready, input out_instr, input out_pc,
        input dbg_count, input misalign_fault, input misalign_pc
    );
`else
    modport master (
        output rom_addr, input rom_q,
        input redirect_valid, input redirect_pc,
        output out_valid, input out_ready, output out_instr, output out_pc,
        output dbg_count
    );
    modport slave (
        input rom_addr, output rom_q,
        output redirect_valid, output redirect_pc,
        input out_valid, output out_ready, input out_instr, input out_pc,
        input dbg_count
    );
`endif
endinterface

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO of fetch entries with push, pop and flush.
// Flush wins over push/pop; storage is not reset, only the pointers.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  fetch_entry_t           wdata_i,
    output fetch_entry_t           rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Next pointer/count values; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push_i && !pop_i)      count_d = count_q + CW'(1);
            else if (!push_i && pop_i) count_d = count_q - CW'(1);
        end
    end

    // Pointer and occupancy registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; written only by a push that is not being flushed.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, reads the combinational ROM and
// buffers {pc, instr} pairs for decode. Redirects flush and restart fetch.
// Optional macro IFETCH_MISALIGN_TRAP_EN: a misaligned redirect target raises
// a sticky fault, records the raw target and halts fetching until reset.
// XLEN must match ifetch_pkg::XLEN since buffered entries use the package type.
module ifetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic     clk,
    input  logic     rst_n,
    ifetch_if.master bus
);
    import ifetch_pkg::*;

    logic [XLEN-1:0]        pc_q, pc_d;
    logic                   push, pop, flush;
    logic                   full, empty;
    logic [$clog2(DEPTH):0] count;
    fetch_entry_t           wr_entry, head;

    assign flush = bus.redirect_valid;
    assign pop   = !empty && bus.out_ready;

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic            fault_q, fault_d;
    logic [XLEN-1:0] mis_pc_q, mis_pc_d;

    // A full buffer may still accept when decode drains the head this cycle.
    assign push = !flush && (!full || pop) && !fault_q;

    // The first misaligned redirect latches the fault and its raw target.
    always_comb begin
        fault_d  = fault_q;
        mis_pc_d = mis_pc_q;
        if (bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00) && !fault_q) begin
            fault_d  = 1'b1;
            mis_pc_d = bus.redirect_pc;
        end
    end

    // Sticky fault state, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q  <= 1'b0;
            mis_pc_q <= '0;
        end else begin
            fault_q  <= fault_d;
            mis_pc_q <= mis_pc_d;
        end
    end

    assign bus.misalign_fault = fault_q;
    assign bus.misalign_pc    = mis_pc_q;
`else
    // A full buffer may still accept when decode drains the head this cycle.
    assign push = !flush && (!full || pop);
`endif

    // Redirect overrides everything; otherwise advance only on a push.
    always_comb begin
        pc_d = pc_q;
        if (bus.redirect_valid) pc_d = align_pc(bus.redirect_pc);
        else if (push)          pc_d = pc_q + XLEN'(PC_STEP);
    end

    // Program counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end

    assign wr_entry = '{pc: pc_q, instr: bus.rom_q};

    ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (wr_entry),
        .rdata_o (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    assign bus.rom_addr  = pc_q;
    assign bus.out_valid = !empty;
    assign bus.out_pc    = head.pc;
    assign bus.out_instr = head.instr;
    assign bus.dbg_count = count;

endmodule
